// File: rtl/msx_cart_pkg.sv
// Shared constants for the MSX cartridge ROM mapper: mapper mode codes,
// loader FSM states, CPU window bounds and the bank register reset image.
package msx_cart_pkg;

  localparam logic [1:0] MAPPER_PLAIN   = 2'd0;
  localparam logic [1:0] MAPPER_ASCII8  = 2'd1;
  localparam logic [1:0] MAPPER_ASCII16 = 2'd2;
  localparam logic [1:0] MAPPER_KONAMI  = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  localparam logic [15:0] WINDOW_LO = 16'h4000;
  localparam logic [15:0] WINDOW_HI = 16'hC000;

  localparam int BANK_W  = 8;
  localparam int COUNT_W = 21;
  // Widest physical address before truncation: 8-bit bank above a 16KB page offset.
  localparam int PHYS_W  = BANK_W + 14;

  localparam logic [3:0][BANK_W-1:0] BANK_RESET = {8'd3, 8'd2, 8'd1, 8'd0};

  function automatic logic inWindow(input logic [15:0] addr);
    return (addr >= WINDOW_LO) && (addr < WINDOW_HI);
  endfunction

endpackage

// File: rtl/cart_rom_mem.sv
// Cartridge image storage: 2**ADDR_WIDTH x 8 simple dual-port RAM with a
// registered, enable-qualified read port.
module cart_rom_mem
  import msx_cart_pkg::*;
#(
  parameter int    ADDR_WIDTH    = 17,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                  clk_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [7:0]            rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]            wr_data_i
);

  logic [7:0] mem_q [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read data is held between reads so the CPU side sees a stable byte.
  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_o <= mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/msx_cart_mapper_rom.sv
// MSX cartridge slot ROM: runtime byte loader into block RAM, bank registers
// for plain/ASCII8/ASCII16/Konami mappers, and the CPU read path.
module msx_cart_mapper_rom
  import msx_cart_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 17,
  parameter string      MEM_INIT_FILE  = "",
  parameter logic [1:0] MAPPER_DEFAULT = MAPPER_PLAIN
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [1:0]   mapper_mode_i,
  input  logic         cs_i,
  input  logic [15:0]  cpu_addr_i,
  input  logic         cpu_rd_i,
  input  logic         cpu_wr_i,
  input  logic [7:0]   cpu_din_i,
  output logic [7:0]   cpu_dout_o,
  input  logic         ld_start_i,
  input  logic         ld_valid_i,
  input  logic [7:0]   ld_data_i,
  input  logic         ld_last_i,
  output logic         ld_ready_o,
  output logic         ld_done_o,
  output logic         ld_overflow_o,
  output logic [20:0]  ld_count_o
);

  state_e                    state_q, state_d;
  logic [COUNT_W-1:0]        ldCount_q, ldCount_d;
  logic                      ldDone_q, ldDone_d;
  logic                      ldOverflow_q, ldOverflow_d;
  logic [3:0][BANK_W-1:0]    bank_q, bank_d;
  logic                      mapped_q, mapped_d;

  logic                      cpuRead;
  logic                      cpuWrite;
  logic                      loadBeat;
  logic                      pastEnd;
  logic                      memWe;
  logic [14:0]               windowOffset;
  logic [1:0]                pageIdx;
  logic [BANK_W-1:0]         konamiBank;
  logic [PHYS_W-1:0]         physFull;
  logic [ADDR_WIDTH-1:0]     physAddr;
  logic [7:0]                memData;

  assign cpuRead  = cs_i & cpu_rd_i;
  assign cpuWrite = cs_i & cpu_wr_i & (state_q == ST_RUN);
  // A byte presented together with ld_start belongs to no load and is dropped.
  assign loadBeat = (state_q == ST_LOAD) & ld_valid_i & ~ld_start_i;
  assign pastEnd  = |ldCount_q[COUNT_W-1:ADDR_WIDTH];
  assign memWe    = loadBeat & ~pastEnd;

  always_comb begin
    windowOffset = 15'(cpu_addr_i - WINDOW_LO);
    pageIdx      = windowOffset[14:13];
    konamiBank   = (pageIdx == 2'd0) ? '0 : bank_q[pageIdx];
    physFull     = '0;
    unique case (mapper_mode_i)
      MAPPER_PLAIN:   physFull = PHYS_W'(windowOffset);
      MAPPER_ASCII8:  physFull = {1'b0, bank_q[pageIdx], cpu_addr_i[12:0]};
      MAPPER_ASCII16: physFull = {bank_q[{1'b0, windowOffset[14]}], cpu_addr_i[13:0]};
      MAPPER_KONAMI:  physFull = {1'b0, konamiBank, cpu_addr_i[12:0]};
    endcase
  end

  // Oversized bank numbers wrap by dropping the bits above the storage size.
  assign physAddr = ADDR_WIDTH'(physFull);

  always_comb begin
    state_d      = state_q;
    ldCount_d    = ldCount_q;
    ldDone_d     = ldDone_q;
    ldOverflow_d = ldOverflow_q;
    bank_d       = bank_q;
    mapped_d     = mapped_q;

    if (cpuRead) begin
      mapped_d = inWindow(cpu_addr_i) && (state_q == ST_RUN);
    end

    if (ld_start_i) begin
      state_d      = ST_LOAD;
      ldCount_d    = '0;
      ldDone_d     = 1'b0;
      ldOverflow_d = 1'b0;
    end else if (loadBeat) begin
      ldCount_d = ldCount_q + COUNT_W'(1);
      if (pastEnd) begin
        ldOverflow_d = 1'b1;
      end
      if (ld_last_i) begin
        state_d  = ST_RUN;
        ldDone_d = 1'b1;
        bank_d   = BANK_RESET;
      end
    end else if (cpuWrite) begin
      unique case (mapper_mode_i)
        MAPPER_PLAIN: ;
        MAPPER_ASCII8: begin
          if (cpu_addr_i[15:13] == 3'b011) begin
            bank_d[cpu_addr_i[12:11]] = cpu_din_i;
          end
        end
        MAPPER_ASCII16: begin
          if (cpu_addr_i[15:11] == 5'b01100) begin
            bank_d[0] = cpu_din_i;
          end else if (cpu_addr_i[15:11] == 5'b01110) begin
            bank_d[1] = cpu_din_i;
          end
        end
        MAPPER_KONAMI: begin
          case (cpu_addr_i[15:13])
            3'b011:  bank_d[1] = cpu_din_i;
            3'b100:  bank_d[2] = cpu_din_i;
            3'b101:  bank_d[3] = cpu_din_i;
            default: ;
          endcase
        end
      endcase
    end
  end

  // Reset deliberately leaves storage alone; only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_RUN;
      ldCount_q    <= '0;
      ldDone_q     <= 1'b0;
      ldOverflow_q <= 1'b0;
      bank_q       <= BANK_RESET;
      mapped_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ldCount_q    <= ldCount_d;
      ldDone_q     <= ldDone_d;
      ldOverflow_q <= ldOverflow_d;
      bank_q       <= bank_d;
      mapped_q     <= mapped_d;
    end
  end

  cart_rom_mem #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .MEM_INIT_FILE (MEM_INIT_FILE)
  ) u_mem (
    .clk_i     (clk_i),
    .rd_en_i   (cpuRead),
    .rd_addr_i (physAddr),
    .rd_data_o (memData),
    .wr_en_i   (memWe),
    .wr_addr_i (ldCount_q[ADDR_WIDTH-1:0]),
    .wr_data_i (ld_data_i)
  );

  assign cpu_dout_o    = mapped_q ? memData : 8'hFF;
  assign ld_ready_o    = (state_q == ST_LOAD);
  assign ld_done_o     = ldDone_q;
  assign ld_overflow_o = ldOverflow_q;
  assign ld_count_o    = ldCount_q;

endmodule

// File: tb/tb_msx_cart_mapper_rom.sv
// Self-checking bench for msx_cart_mapper_rom: a 128KB instance against a
// byte-array reference model, plus a 32KB instance for overflow and wrap.
module tb_msx_cart_mapper_rom;

  localparam int SIZE = 1 << 17;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  mapperMode;
  logic        cs;
  logic [15:0] cpuAddr;
  logic        cpuRd;
  logic        cpuWr;
  logic [7:0]  cpuDin;
  logic        ldStart;
  logic        ldValid;
  logic [7:0]  ldData;
  logic        ldLast;

  logic [7:0]  cpuDout, cpuDoutSmall;
  logic        ldReady, ldReadySmall;
  logic        ldDone, ldDoneSmall;
  logic        ldOverflow, ldOverflowSmall;
  logic [20:0] ldCount, ldCountSmall;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] modelMem [SIZE];
  bit         modelKnown [SIZE];
  int         modelBank [4];

  typedef struct {
    string       name;
    logic [1:0]  mode;
    bit          doWr;
    logic [15:0] wrAddr;
    logic [7:0]  wrData;
    logic [15:0] rdAddr;
    int          expPhys;
  } vec_t;

  vec_t vectors[$];

  always #5 clock = ~clock;

  msx_cart_mapper_rom #(
    .ADDR_WIDTH     (17),
    .MEM_INIT_FILE  (""),
    .MAPPER_DEFAULT (2'd0)
  ) dut (
    .clk_i         (clock),
    .reset_i       (reset),
    .mapper_mode_i (mapperMode),
    .cs_i          (cs),
    .cpu_addr_i    (cpuAddr),
    .cpu_rd_i      (cpuRd),
    .cpu_wr_i      (cpuWr),
    .cpu_din_i     (cpuDin),
    .cpu_dout_o    (cpuDout),
    .ld_start_i    (ldStart),
    .ld_valid_i    (ldValid),
    .ld_data_i     (ldData),
    .ld_last_i     (ldLast),
    .ld_ready_o    (ldReady),
    .ld_done_o     (ldDone),
    .ld_overflow_o (ldOverflow),
    .ld_count_o    (ldCount)
  );

  msx_cart_mapper_rom #(
    .ADDR_WIDTH     (15),
    .MEM_INIT_FILE  (""),
    .MAPPER_DEFAULT (2'd0)
  ) dutSmall (
    .clk_i         (clock),
    .reset_i       (reset),
    .mapper_mode_i (mapperMode),
    .cs_i          (cs),
    .cpu_addr_i    (cpuAddr),
    .cpu_rd_i      (cpuRd),
    .cpu_wr_i      (cpuWr),
    .cpu_din_i     (cpuDin),
    .cpu_dout_o    (cpuDoutSmall),
    .ld_start_i    (ldStart),
    .ld_valid_i    (ldValid),
    .ld_data_i     (ldData),
    .ld_last_i     (ldLast),
    .ld_ready_o    (ldReadySmall),
    .ld_done_o     (ldDoneSmall),
    .ld_overflow_o (ldOverflowSmall),
    .ld_count_o    (ldCountSmall)
  );

  function automatic logic [7:0] patOf(input int sel, input int i);
    case (sel)
      0:       return 8'((i * 7) & 255);
      1:       return (i < 32768) ? 8'((i * 3 + 1) & 255) : 8'hA5;
      2:       return 8'((i + 'h33) & 255);
      default: return 8'((i + 'hC0) & 255);
    endcase
  endfunction

  // Reference address map: page index times page size, modulo storage size.
  function automatic int physOf(input int mode, input int addr);
    int off;
    int page;
    int bank;
    if (addr < 'h4000 || addr >= 'hC000) return -1;
    off = addr - 'h4000;
    case (mode)
      0: return off;
      1: begin
        page = off / 8192;
        return (modelBank[page] * 8192 + addr % 8192) % SIZE;
      end
      2: begin
        page = off / 16384;
        return (modelBank[page] * 16384 + addr % 16384) % SIZE;
      end
      default: begin
        page = off / 8192;
        bank = (page == 0) ? 0 : modelBank[page];
        return (bank * 8192 + addr % 8192) % SIZE;
      end
    endcase
  endfunction

  function automatic void modelBankWrite(input int mode, input int addr, input int data);
    case (mode)
      1: if (addr >= 'h6000 && addr < 'h8000) modelBank[(addr - 'h6000) / 'h800] = data;
      2: begin
        if (addr >= 'h6000 && addr < 'h6800) modelBank[0] = data;
        else if (addr >= 'h7000 && addr < 'h7800) modelBank[1] = data;
      end
      3: begin
        if (addr >= 'h6000 && addr < 'h8000) modelBank[1] = data;
        else if (addr >= 'h8000 && addr < 'hA000) modelBank[2] = data;
        else if (addr >= 'hA000 && addr < 'hC000) modelBank[3] = data;
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel, input logic [15:0] addr, input bit rd, input bit wr,
                               input logic [7:0] din);
    cs      = sel;
    cpuAddr = addr;
    cpuRd   = rd;
    cpuWr   = wr;
    cpuDin  = din;
    tick();
    cs    = 1'b0;
    cpuRd = 1'b0;
    cpuWr = 1'b0;
  endtask

  task automatic cpuOp(input bit sel, input logic [15:0] addr, input bit rd, input bit wr,
                       input logic [7:0] din, output int phys);
    phys = physOf(int'(mapperMode), int'(addr));
    if (sel && wr) modelBankWrite(int'(mapperMode), int'(addr), int'(din));
    applyStimulus(sel, addr, rd, wr, din);
  endtask

  task automatic readCheck(input string name, input logic [15:0] addr);
    int phys;
    cpuOp(1'b1, addr, 1'b1, 1'b0, 8'h00, phys);
    if (phys < 0) checkOutput(name, cpuDout, 8'hFF);
    else if (modelKnown[phys]) checkOutput(name, cpuDout, modelMem[phys]);
  endtask

  task automatic pulseStart();
    ldStart = 1'b1;
    tick();
    ldStart = 1'b0;
    checkOutput("start_ready", ldReady, 1);
    checkOutput("start_count", ldCount, 0);
    checkOutput("start_done", ldDone, 0);
  endtask

  task automatic feedBytes(input int n, input int sel, input bit withLast);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      bit probe;
      d = patOf(sel, i);
      probe = (i % 8192) == 77;
      ldValid = 1'b1;
      ldData  = d;
      ldLast  = withLast && (i == n - 1);
      if (probe) begin
        cs = 1'b1; cpuRd = 1'b1; cpuAddr = 16'h4000;
      end
      tick();
      cs = 1'b0; cpuRd = 1'b0;
      if (probe) checkOutput("load_read_ff", cpuDout, 8'hFF);
      if (i < SIZE) begin
        modelMem[i]   = d;
        modelKnown[i] = 1'b1;
      end
    end
    ldValid = 1'b0;
    ldLast  = 1'b0;
    if (withLast) modelBank = '{0, 1, 2, 3};
  endtask

  task automatic addVec(input string name, input logic [1:0] mode, input bit doWr, input logic [15:0] wrAddr,
                        input logic [7:0] wrData, input logic [15:0] rdAddr, input int expPhys);
    vec_t v;
    v.name = name; v.mode = mode; v.doWr = doWr; v.wrAddr = wrAddr;
    v.wrData = wrData; v.rdAddr = rdAddr; v.expPhys = expPhys;
    vectors.push_back(v);
  endtask

  initial begin
    int phys;
    logic [7:0] lastDout;
    bit lastKnown;

    // Expected physical byte after the 40000-byte (i*7)&FF image; -1 means 8'hFF.
    addVec("plain_4000",     2'd0, 0, 16'h0000, 8'h00, 16'h4000, 'h0000);
    addVec("plain_bfff",     2'd0, 0, 16'h0000, 8'h00, 16'hBFFF, 'h7FFF);
    addVec("plain_wr_ign",   2'd0, 1, 16'h6000, 8'h05, 16'h6000, 'h2000);
    addVec("plain_c000",     2'd0, 0, 16'h0000, 8'h00, 16'hC000, -1);
    addVec("plain_0000",     2'd0, 0, 16'h0000, 8'h00, 16'h0000, -1);
    addVec("plain_3fff",     2'd0, 0, 16'h0000, 8'h00, 16'h3FFF, -1);
    addVec("a8_reset_b2",    2'd1, 0, 16'h0000, 8'h00, 16'h8010, 'h4010);
    addVec("a8_b1",          2'd1, 1, 16'h6800, 8'h04, 16'h6123, 'h8123);
    addVec("a8_b3",          2'd1, 1, 16'h7FFF, 8'h03, 16'hA456, 'h6456);
    addVec("a8_b0",          2'd1, 1, 16'h6000, 8'h01, 16'h4FFF, 'h2FFF);
    addVec("a16_b1",         2'd2, 1, 16'h7000, 8'h02, 16'h8001, 'h8001);
    addVec("a16_wrap",       2'd2, 1, 16'h6000, 8'h09, 16'h4001, 'h4001);
    addVec("a16_6800_ign",   2'd2, 1, 16'h6800, 8'h07, 16'h4001, 'h4001);
    addVec("kon_page0",      2'd3, 1, 16'h6000, 8'h04, 16'h4010, 'h0010);
    addVec("kon_b1",         2'd3, 0, 16'h0000, 8'h00, 16'h6010, 'h8010);
    addVec("kon_b3",         2'd3, 1, 16'hA000, 8'h01, 16'hA010, 'h2010);
    addVec("kon_b2",         2'd3, 1, 16'h8000, 8'h00, 16'h9FFF, 'h1FFF);
    addVec("kon_c000",       2'd3, 0, 16'h0000, 8'h00, 16'hC000, -1);

    reset = 1'b1; mapperMode = 2'd0; cs = 1'b0; cpuAddr = '0; cpuRd = 1'b0; cpuWr = 1'b0;
    cpuDin = '0; ldStart = 1'b0; ldValid = 1'b0; ldData = '0; ldLast = 1'b0;
    modelBank = '{0, 1, 2, 3};
    for (int i = 0; i < SIZE; i++) modelKnown[i] = 1'b0;

    tick();
    tick();
    checkOutput("reset_dout", cpuDout, 8'hFF);
    checkOutput("reset_ready", ldReady, 0);
    checkOutput("reset_done", ldDone, 0);
    checkOutput("reset_overflow", ldOverflow, 0);
    checkOutput("reset_count", ldCount, 0);
    reset = 1'b0;
    tick();

    $display("[TB] loading 40000-byte image");
    pulseStart();
    feedBytes(40000, 0, 1'b1);
    checkOutput("load_done", ldDone, 1);
    checkOutput("load_count", ldCount, 40000);
    checkOutput("load_overflow", ldOverflow, 0);
    checkOutput("load_ready_low", ldReady, 0);
    checkOutput("small_overflow", ldOverflowSmall, 1);
    checkOutput("small_done", ldDoneSmall, 1);

    foreach (vectors[k]) begin
      mapperMode = vectors[k].mode;
      if (vectors[k].doWr) cpuOp(1'b1, vectors[k].wrAddr, 1'b0, 1'b1, vectors[k].wrData, phys);
      cpuOp(1'b1, vectors[k].rdAddr, 1'b1, 1'b0, 8'h00, phys);
      checkOutput(vectors[k].name, cpuDout,
                  (vectors[k].expPhys < 0) ? 8'hFF : patOf(0, vectors[k].expPhys));
    end

    // Bank write and read in the same cycle: the read still sees the old bank.
    mapperMode = 2'd1;
    cpuOp(1'b1, 16'h6800, 1'b1, 1'b1, 8'h03, phys);
    checkOutput("same_cycle_old", cpuDout, patOf(0, 'h8800));
    cpuOp(1'b1, 16'h6800, 1'b1, 1'b0, 8'h00, phys);
    checkOutput("same_cycle_new", cpuDout, patOf(0, 'h6800));
    applyStimulus(1'b0, 16'h4000, 1'b1, 1'b0, 8'h00);
    checkOutput("dout_hold", cpuDout, patOf(0, 'h6800));

    lastKnown = 1'b0;
    lastDout  = 8'hFF;
    for (int n = 0; n < 400; n++) begin
      bit sel;
      bit rd;
      bit wr;
      logic [15:0] addr;
      logic [7:0] din;
      if ($urandom_range(0, 7) == 0) mapperMode = 2'($urandom_range(0, 3));
      sel  = $urandom_range(0, 7) != 0;
      rd   = $urandom_range(0, 1) == 1;
      wr   = $urandom_range(0, 2) == 0;
      addr = ($urandom_range(0, 1) == 1) ? 16'($urandom_range('h6000, 'hBFFF)) : 16'($urandom);
      din  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 20)) : 8'($urandom_range(0, 4));
      cpuOp(sel, addr, rd, wr, din, phys);
      if (sel && rd) begin
        if (phys < 0) begin
          lastDout = 8'hFF; lastKnown = 1'b1;
        end else begin
          lastDout = modelMem[phys]; lastKnown = modelKnown[phys];
        end
      end
      if (lastKnown) checkOutput("random_read", cpuDout, lastDout);
    end

    $display("[TB] restart and reset during load");
    mapperMode = 2'd1;
    cpuOp(1'b1, 16'h6800, 1'b0, 1'b1, 8'h03, phys);
    pulseStart();
    feedBytes(100, 2, 1'b0);
    checkOutput("partial_count", ldCount, 100);
    pulseStart();
    feedBytes(10, 3, 1'b0);
    checkOutput("restart_count", ldCount, 10);
    checkOutput("restart_overflow", ldOverflow, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelBank = '{0, 1, 2, 3};
    checkOutput("midreset_ready", ldReady, 0);
    checkOutput("midreset_done", ldDone, 0);
    checkOutput("midreset_count", ldCount, 0);
    checkOutput("midreset_dout", cpuDout, 8'hFF);
    readCheck("midreset_bank1", 16'h6800);
    readCheck("partial_byte5", 16'h4005);
    readCheck("partial_byte50", 16'h4032);

    $display("[TB] loading 33000-byte image into both sizes");
    pulseStart();
    feedBytes(33000, 1, 1'b1);
    checkOutput("ovf_done", ldDoneSmall, 1);
    checkOutput("ovf_count", ldCountSmall, 33000);
    checkOutput("ovf_flag", ldOverflowSmall, 1);
    checkOutput("big_no_ovf", ldOverflow, 0);
    checkOutput("big_count", ldCount, 33000);
    mapperMode = 2'd0;
    readCheck("big_byte0", 16'h4000);
    checkOutput("ovf_byte0", cpuDoutSmall, patOf(1, 0));
    cpuOp(1'b1, 16'hBFFF, 1'b1, 1'b0, 8'h00, phys);
    checkOutput("ovf_last", cpuDoutSmall, patOf(1, 32767));
    mapperMode = 2'd1;
    cpuOp(1'b1, 16'h6000, 1'b0, 1'b1, 8'h04, phys);
    readCheck("big_bank4", 16'h4000);
    checkOutput("small_bank_wrap", cpuDoutSmall, patOf(1, 0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
